// File: rtl/mem_stall_pkg.sv
// rtl/mem_stall_pkg.sv - shared types and defaults for the memory stall controller
package mem_stall_pkg;

    // Default width of the miss and write-back statistics counters
    localparam int CNT_W_DEF = 16;

    // Miss-handling FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        UPDATE    = 2'd3
    } state_t;

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// rtl/mem_stall_ctrl_if.sv - off-chip memory handshake between stall controller and memory
interface mem_stall_ctrl_if;

    logic mem_req_o;   // one-cycle request pulse
    logic mem_we_o;    // 1 = write-back, 0 = refill read
    logic mem_ack_i;   // single-cycle completion pulse

    modport master (
        output mem_req_o,
        output mem_we_o,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        output mem_ack_i
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count events, stopping at all-ones so the statistic never wraps
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - data-cache miss FSM that stalls the pipeline during write-back/refill
module mem_stall_ctrl
    import mem_stall_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   req_i,
    input  logic                   hit_i,
    input  logic                   dirty_i,
    mem_stall_ctrl_if.master       mem,
    output logic                   stall_o,
    output logic                   refill_we_o,
    output logic [CNT_W-1:0]       miss_cnt_o,
    output logic [CNT_W-1:0]       wb_cnt_o
);

    state_t state_q;
    state_t state_d;
    logic   first_q;      // high in the first cycle of any state visit
    logic   miss_det;
    logic   wb_start;
    logic   mem_we;
    logic   refill_we;
    logic   stall;

    // State register; first_q marks the cycle right after a state change
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
        end
    end

    // Next-state and Moore/Mealy outputs; stall is combinational in the miss-detect cycle
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_we    = 1'b0;
        refill_we = 1'b0;
        miss_det  = 1'b0;
        wb_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && req_i && !hit_i) begin
                    miss_det = 1'b1;
                    stall    = 1'b1;
                    wb_start = dirty_i;
                    state_d  = dirty_i ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                stall  = 1'b1;
                mem_we = 1'b1;
                if (mem.mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (mem.mem_ack_i) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                stall     = 1'b1;
                refill_we = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_o       = stall;
    assign refill_we_o   = refill_we;
    assign mem.mem_we_o  = mem_we;
    // Each WRITEBACK/REFILL visit is entered from a different state, so first_q gives one pulse per visit
    assign mem.mem_req_o = first_q && ((state_q == WRITEBACK) || (state_q == REFILL));

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (miss_det),
        .cnt_o (miss_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_wb_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (wb_start),
        .cnt_o (wb_cnt_o)
    );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb/tb_mem_stall_ctrl.sv - directed self-checking bench for mem_stall_ctrl
module tb_mem_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic req;
    logic hit;
    logic dirty;
    logic force_ack;
    logic model_ack;

    logic        stall;
    logic        refill_we;
    logic [15:0] miss_cnt;
    logic [15:0] wb_cnt;
    logic        stall2;
    logic        refill_we2;
    logic [1:0]  miss_cnt2;
    logic [1:0]  wb_cnt2;

    mem_stall_ctrl_if mif ();
    mem_stall_ctrl_if mif2 ();

    assign mif.mem_ack_i  = model_ack | force_ack;
    assign mif2.mem_ack_i = model_ack | force_ack;

    mem_stall_ctrl #(.CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .start_i     (start),
        .req_i       (req),
        .hit_i       (hit),
        .dirty_i     (dirty),
        .mem         (mif.master),
        .stall_o     (stall),
        .refill_we_o (refill_we),
        .miss_cnt_o  (miss_cnt),
        .wb_cnt_o    (wb_cnt)
    );

    // Narrow-counter copy, driven in lockstep with the main instance
    mem_stall_ctrl #(.CNT_W(2)) dut2 (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .start_i     (start),
        .req_i       (req),
        .hit_i       (hit),
        .dirty_i     (dirty),
        .mem         (mif2.master),
        .stall_o     (stall2),
        .refill_we_o (refill_we2),
        .miss_cnt_o  (miss_cnt2),
        .wb_cnt_o    (wb_cnt2)
    );

    int   ack_cnt    = 0;
    int   stall_tot  = 0;
    int   req_tot    = 0;
    int   refill_tot = 0;
    logic we_log [0:255];

    int tests = 0;
    int fails = 0;

    // Memory model (ack 4 cycles after the request pulse) and running event totals
    always @(negedge clk) begin
        model_ack = 1'b0;
        if (ack_cnt != 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) model_ack = 1'b1;
        end
        if (mif.mem_req_o) ack_cnt = 4;
        if (stall) stall_tot = stall_tot + 1;
        if (mif.mem_req_o) begin
            we_log[req_tot[7:0]] = mif.mem_we_o;
            req_tot = req_tot + 1;
        end
        if (refill_we) refill_tot = refill_tot + 1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        req = 1'b0;
        hit = 1'b1;
        dirty = 1'b0;
        force_ack = 1'b0;
        cyc(6);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tests++; if (mif.mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mif.mem_req_o); end
        tests++; if (mif.mem_we_o !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mif.mem_we_o); end
        tests++; if (refill_we !== 1'b0) begin fails++; $display("FAIL reset_refill_we: got %b expected 0", refill_we); end
        tests++; if (miss_cnt !== 16'd0) begin fails++; $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); end
        tests++; if (wb_cnt !== 16'd0) begin fails++; $display("FAIL reset_wb_cnt: got %0d expected 0", wb_cnt); end
        tests++; if (miss_cnt2 !== 2'd0) begin fails++; $display("FAIL reset_miss_cnt2: got %0d expected 0", miss_cnt2); end
    endtask

    task automatic test_hits();
        int sb, rb;
        do_reset();
        sb = stall_tot; rb = req_tot;
        start = 1'b1; req = 1'b1; hit = 1'b1;
        cyc(10);
        req = 1'b0;
        tests++; if (stall_tot - sb != 0) begin fails++; $display("FAIL hit_stall_cycles: got %0d expected 0", stall_tot - sb); end
        tests++; if (req_tot - rb != 0) begin fails++; $display("FAIL hit_req_pulses: got %0d expected 0", req_tot - rb); end
        tests++; if (miss_cnt !== 16'd0) begin fails++; $display("FAIL hit_miss_cnt: got %0d expected 0", miss_cnt); end
        tests++; if (wb_cnt !== 16'd0) begin fails++; $display("FAIL hit_wb_cnt: got %0d expected 0", wb_cnt); end
    endtask

    task automatic test_clean_miss();
        int sb, rb, fb;
        do_reset();
        sb = stall_tot; rb = req_tot; fb = refill_tot;
        start = 1'b1; req = 1'b1; hit = 1'b0; dirty = 1'b0;
        cyc(6);
        hit = 1'b1;
        cyc(4);
        req = 1'b0;
        tests++; if (stall_tot - sb != 7) begin fails++; $display("FAIL clean_stall_cycles: got %0d expected 7", stall_tot - sb); end
        tests++; if (req_tot - rb != 1) begin fails++; $display("FAIL clean_req_pulses: got %0d expected 1", req_tot - rb); end
        tests++; if (we_log[rb[7:0]] !== 1'b0) begin fails++; $display("FAIL clean_req_we: got %b expected 0", we_log[rb[7:0]]); end
        tests++; if (refill_tot - fb != 1) begin fails++; $display("FAIL clean_refill_pulses: got %0d expected 1", refill_tot - fb); end
        tests++; if (miss_cnt !== 16'd1) begin fails++; $display("FAIL clean_miss_cnt: got %0d expected 1", miss_cnt); end
        tests++; if (wb_cnt !== 16'd0) begin fails++; $display("FAIL clean_wb_cnt: got %0d expected 0", wb_cnt); end
    endtask

    task automatic test_dirty_miss();
        int sb, rb, fb;
        do_reset();
        sb = stall_tot; rb = req_tot; fb = refill_tot;
        start = 1'b1; req = 1'b1; hit = 1'b0; dirty = 1'b1;
        cyc(1);
        tests++; if (mif.mem_req_o !== 1'b1) begin fails++; $display("FAIL dirty_first_req: got %b expected 1", mif.mem_req_o); end
        tests++; if (mif.mem_we_o !== 1'b1) begin fails++; $display("FAIL dirty_wb_we: got %b expected 1", mif.mem_we_o); end
        cyc(1);
        tests++; if (mif.mem_req_o !== 1'b0) begin fails++; $display("FAIL dirty_req_width: got %b expected 0", mif.mem_req_o); end
        cyc(9);
        hit = 1'b1;
        cyc(4);
        req = 1'b0; dirty = 1'b0;
        tests++; if (stall_tot - sb != 12) begin fails++; $display("FAIL dirty_stall_cycles: got %0d expected 12", stall_tot - sb); end
        tests++; if (req_tot - rb != 2) begin fails++; $display("FAIL dirty_req_pulses: got %0d expected 2", req_tot - rb); end
        tests++; if (we_log[rb[7:0]] !== 1'b1) begin fails++; $display("FAIL dirty_req0_we: got %b expected 1", we_log[rb[7:0]]); end
        rb = rb + 1;
        tests++; if (we_log[rb[7:0]] !== 1'b0) begin fails++; $display("FAIL dirty_req1_we: got %b expected 0", we_log[rb[7:0]]); end
        tests++; if (refill_tot - fb != 1) begin fails++; $display("FAIL dirty_refill_pulses: got %0d expected 1", refill_tot - fb); end
        tests++; if (miss_cnt !== 16'd1) begin fails++; $display("FAIL dirty_miss_cnt: got %0d expected 1", miss_cnt); end
        tests++; if (wb_cnt !== 16'd1) begin fails++; $display("FAIL dirty_wb_cnt: got %0d expected 1", wb_cnt); end
    endtask

    task automatic test_idle_blocked();
        int sb, rb, fb;
        do_reset();
        sb = stall_tot; rb = req_tot; fb = refill_tot;
        start = 1'b0; req = 1'b1; hit = 1'b0;
        cyc(3);
        force_ack = 1'b1;
        cyc(1);
        force_ack = 1'b0;
        cyc(3);
        start = 1'b1; hit = 1'b1;
        cyc(2);
        start = 1'b0; req = 1'b0;
        tests++; if (stall_tot - sb != 0) begin fails++; $display("FAIL blocked_stall_cycles: got %0d expected 0", stall_tot - sb); end
        tests++; if (req_tot - rb != 0) begin fails++; $display("FAIL blocked_req_pulses: got %0d expected 0", req_tot - rb); end
        tests++; if (refill_tot - fb != 0) begin fails++; $display("FAIL blocked_refill_pulses: got %0d expected 0", refill_tot - fb); end
        tests++; if (miss_cnt !== 16'd0) begin fails++; $display("FAIL blocked_miss_cnt: got %0d expected 0", miss_cnt); end
    endtask

    task automatic test_reset_mid();
        int sb, fb;
        do_reset();
        start = 1'b1; req = 1'b1; hit = 1'b0; dirty = 1'b0;
        cyc(2);
        start = 1'b0;
        cyc(1);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL inflight_stall: got %b expected 1", stall); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL midrst_stall: got %b expected 0", stall); end
        tests++; if (mif.mem_req_o !== 1'b0) begin fails++; $display("FAIL midrst_mem_req: got %b expected 0", mif.mem_req_o); end
        tests++; if (refill_we !== 1'b0) begin fails++; $display("FAIL midrst_refill_we: got %b expected 0", refill_we); end
        tests++; if (miss_cnt !== 16'd0) begin fails++; $display("FAIL midrst_miss_cnt: got %0d expected 0", miss_cnt); end
        tests++; if (miss_cnt2 !== 2'd0) begin fails++; $display("FAIL midrst_miss_cnt2: got %0d expected 0", miss_cnt2); end
        cyc(1);
        rst_n = 1'b1;
        sb = stall_tot; fb = refill_tot;
        cyc(10);
        req = 1'b0;
        tests++; if (refill_tot - fb != 0) begin fails++; $display("FAIL postrst_refill_pulses: got %0d expected 0", refill_tot - fb); end
        tests++; if (stall_tot - sb != 0) begin fails++; $display("FAIL postrst_stall_cycles: got %0d expected 0", stall_tot - sb); end
    endtask

    task automatic test_back_to_back_sat();
        int sb, rb, fb;
        do_reset();
        sb = stall_tot; rb = req_tot; fb = refill_tot;
        start = 1'b1; req = 1'b1; hit = 1'b0; dirty = 1'b0;
        cyc(34);
        hit = 1'b1;
        cyc(3);
        req = 1'b0;
        tests++; if (stall_tot - sb != 35) begin fails++; $display("FAIL b2b_stall_cycles: got %0d expected 35", stall_tot - sb); end
        tests++; if (req_tot - rb != 5) begin fails++; $display("FAIL b2b_req_pulses: got %0d expected 5", req_tot - rb); end
        tests++; if (refill_tot - fb != 5) begin fails++; $display("FAIL b2b_refill_pulses: got %0d expected 5", refill_tot - fb); end
        tests++; if (miss_cnt !== 16'd5) begin fails++; $display("FAIL b2b_miss_cnt: got %0d expected 5", miss_cnt); end
        tests++; if (miss_cnt2 !== 2'd3) begin fails++; $display("FAIL sat_miss_cnt2: got %0d expected 3", miss_cnt2); end
        tests++; if (wb_cnt2 !== 2'd0) begin fails++; $display("FAIL sat_wb_cnt2: got %0d expected 0", wb_cnt2); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        req = 1'b0;
        hit = 1'b1;
        dirty = 1'b0;
        force_ack = 1'b0;
        model_ack = 1'b0;
        test_reset();
        test_hits();
        test_clean_miss();
        test_dirty_miss();
        test_idle_blocked();
        test_reset_mid();
        test_back_to_back_sat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
